// File: rtl/code_playback.sv
// Replays a column-encoded guess code onto four symbol LEDs, one position at a time,
// with a start/busy/done handshake and a sticky flag for malformed positions.
module code_playback #(
   parameter int ON_CYCLES  = 4,
   parameter int OFF_CYCLES = 2,
   parameter int MAXLEN     = 7
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [0:MAXLEN-1] s1,
   input  logic [0:MAXLEN-1] s2,
   input  logic [0:MAXLEN-1] s3,
   input  logic [0:MAXLEN-1] s4,
   input  logic [3:0]        len,
   output logic              led1,
   output logic              led2,
   output logic              led3,
   output logic              led4,
   output logic [3:0]        pos,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int MAXT = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
   localparam int TW   = $clog2(MAXT + 1);
   localparam int PW   = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;
   localparam logic [TW-1:0] ON_LAST  = TW'(ON_CYCLES - 1);
   localparam logic [TW-1:0] OFF_LAST = TW'((OFF_CYCLES > 0) ? OFF_CYCLES - 1 : 0);
   localparam logic [3:0]    MAXLEN_L = 4'(MAXLEN);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SHOW = 2'd1,
      GAP  = 2'd2,
      FIN  = 2'd3
   } state_t;

   state_t            state_r, state_s;
   logic [TW-1:0]     timer_r, timer_s;
   logic [3:0]        pos_r, pos_s;
   logic [3:0]        len_r, len_s;
   logic [0:MAXLEN-1] s1_r, s2_r, s3_r, s4_r;
   logic [0:MAXLEN-1] s1_s, s2_s, s3_s, s4_s;
   logic [3:0]        col_s;
   logic [3:0]        led_r, led_s;
   logic              busy_r, done_r, err_r, err_s;
   logic              accept_s, show_entry_s;

   function automatic logic [2:0] popcount4(input logic [3:0] v);
      popcount4 = {2'b00, v[3]} + {2'b00, v[2]} + {2'b00, v[1]} + {2'b00, v[0]};
   endfunction

   function automatic logic [3:0] column(input logic [0:MAXLEN-1] a, input logic [0:MAXLEN-1] b,
                                         input logic [0:MAXLEN-1] c, input logic [0:MAXLEN-1] d,
                                         input logic [PW-1:0] k);
      column = {a[k], b[k], c[k], d[k]};
   endfunction

   // Next-state, timer, position and snapshot selection; output values are derived from the next state.
   always_comb begin
      state_s      = state_r;
      timer_s      = timer_r;
      pos_s        = pos_r;
      len_s        = len_r;
      s1_s         = s1_r;
      s2_s         = s2_r;
      s3_s         = s3_r;
      s4_s         = s4_r;
      accept_s     = 1'b0;
      show_entry_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               accept_s = 1'b1;
               s1_s     = s1;
               s2_s     = s2;
               s3_s     = s3;
               s4_s     = s4;
               len_s    = (len > MAXLEN_L) ? MAXLEN_L : len;
               pos_s    = 4'd0;
               timer_s  = {TW{1'b0}};
               if (len_s == 4'd0) begin
                  state_s = FIN;
               end else begin
                  state_s      = SHOW;
                  show_entry_s = 1'b1;
               end
            end else begin
               state_s = IDLE;
            end
         end
         SHOW: begin
            if (timer_r == ON_LAST) begin
               timer_s = {TW{1'b0}};
               if (OFF_CYCLES > 0) begin
                  state_s = GAP;
               end else if (pos_r == len_r - 4'd1) begin
                  state_s = FIN;
               end else begin
                  pos_s        = pos_r + 4'd1;
                  state_s      = SHOW;
                  show_entry_s = 1'b1;
               end
            end else begin
               timer_s = timer_r + 1'b1;
            end
         end
         GAP: begin
            if (timer_r == OFF_LAST) begin
               timer_s = {TW{1'b0}};
               if (pos_r == len_r - 4'd1) begin
                  state_s = FIN;
               end else begin
                  pos_s        = pos_r + 4'd1;
                  state_s      = SHOW;
                  show_entry_s = 1'b1;
               end
            end else begin
               timer_s = timer_r + 1'b1;
            end
         end
         FIN: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase

      col_s = column(s1_s, s2_s, s3_s, s4_s, pos_s[PW-1:0]);
      if (state_s == SHOW) begin
         led_s = col_s;
      end else begin
         led_s = 4'b0000;
      end
      // A malformed position is flagged on the cycle its symbols first appear.
      if (show_entry_s && (popcount4(col_s) != 3'd1)) begin
         err_s = 1'b1;
      end else if (accept_s) begin
         err_s = 1'b0;
      end else begin
         err_s = err_r;
      end
   end

   // State, snapshot and registered output update.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
         timer_r <= {TW{1'b0}};
         pos_r   <= 4'd0;
         len_r   <= 4'd0;
         s1_r    <= {MAXLEN{1'b0}};
         s2_r    <= {MAXLEN{1'b0}};
         s3_r    <= {MAXLEN{1'b0}};
         s4_r    <= {MAXLEN{1'b0}};
         led_r   <= 4'b0000;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         state_r <= state_s;
         timer_r <= timer_s;
         pos_r   <= pos_s;
         len_r   <= len_s;
         s1_r    <= s1_s;
         s2_r    <= s2_s;
         s3_r    <= s3_s;
         s4_r    <= s4_s;
         led_r   <= led_s;
         busy_r  <= (state_s == SHOW) || (state_s == GAP);
         done_r  <= (state_s == FIN);
         err_r   <= err_s;
      end
   end

   assign led1 = led_r[3];
   assign led2 = led_r[2];
   assign led3 = led_r[1];
   assign led4 = led_r[0];
   assign pos  = pos_r;
   assign busy = busy_r;
   assign done = done_r;
   assign err  = err_r;

endmodule

// File: doc/code_playback.md
Name: code_playback

Overview:
- Reader for the guess-code entry block: replays a stored code sequence onto four symbol LEDs, one position at a time.
- Input is the column-encoded code from the entry block: four 7-bit vectors plus an entry count. Bit k of column j set means position k holds symbol j.
- Used to show player A's code after a loss, or player B's guess for review.
- Simple start/busy/done handshake toward the game controller.

Parameters:
- ON_CYCLES, 4, clocks each position's symbol is driven on the LEDs; must be >= 1.
- OFF_CYCLES, 2, blank clocks after each position; 0 is legal (back-to-back).
- MAXLEN, 7, maximum positions; also the column width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request playback; sampled on clk.
- s1  input  [0:MAXLEN-1]  column for symbol 1; index 0 = first entered position.
- s2  input  [0:MAXLEN-1]  column for symbol 2.
- s3  input  [0:MAXLEN-1]  column for symbol 3.
- s4  input  [0:MAXLEN-1]  column for symbol 4.
- len  input  4  number of valid positions; values above MAXLEN are clamped to MAXLEN.
- led1..led4  output  1 each  symbol display for the current position.
- pos  output  4  index of the position being shown.
- busy  output  1  playback in progress.
- done  output  1  one-cycle completion pulse.
- err  output  1  sticky flag: some position had zero symbols or more than one symbol set.

Behaviour:
- Reset is asynchronous and active-high. On reset: state=IDLE; led1..4=0, pos=0, busy=0, done=0, err=0; snapshot registers cleared. Reset mid-playback aborts immediately, and done is not pulsed.
- FSM states are IDLE, SHOW, GAP, FIN.
- IDLE, start=1 at a clk edge (accept):
  - Snapshot s1..s4 and clamped len into internal registers. Later input changes have no effect.
  - Clear err.
  - If clamped len=0, go to FIN. Otherwise go to SHOW with pos=0 and the timer loaded.
- SHOW:
  - ledj = snapshot sj[pos]; busy=1.
  - Lasts exactly ON_CYCLES cycles.
  - Popcount of {s1..s4}[pos] is checked on the first SHOW cycle; if it is not 1, set err. The LEDs still show the raw bits.
  - Then go to GAP, or skip GAP when OFF_CYCLES=0.
- GAP:
  - All leds 0; busy=1; pos holds its value.
  - Lasts exactly OFF_CYCLES cycles.
  - Then: if pos = len-1, go to FIN; otherwise pos increments and the FSM goes to SHOW.
- FIN:
  - done=1 and busy=0 for exactly one cycle, leds=0, then IDLE.
  - pos holds the last shown index until the next accept.
- Outputs are registered. LEDs first light in the cycle after the accepting edge.
- Total busy cycles = len*(ON_CYCLES+OFF_CYCLES). done follows in the next cycle.
- start while busy or in FIN is ignored; it is not queued.
- start held high continuously: a new playback is accepted in the first IDLE cycle after FIN, so back-to-back runs have a single idle cycle between them.
- Timer width is ceil(log2(max(ON_CYCLES,OFF_CYCLES)+1)). It must not wrap; compare against the terminal value.
- pos never exceeds MAXLEN-1.

Test Plan:
- Basic order (defaults): s1=1000000, s2=0100000, s3=0010000, s4=0001000, len=4, start pulse.
  - Required: led1, led2, led3, led4 each lit for 4 cycles in that order, with 2 blank cycles after each.
  - busy high 24 cycles, then done=1 for 1 cycle; err=0.
- Full length and clamp: len=7 then len=12, with a valid one-hot column pattern.
  - Required: 7 positions shown in both cases; pos ends at 6; busy 42 cycles.
- Error flag: position 2 has s1 and s3 both set; position 4 has no bits set; len=5.
  - Required: err rises in the first SHOW cycle of pos=2 and stays 1 after done.
  - Required: LEDs at pos=2 show 1010, at pos=4 show 0000; the next accepted start clears err.
- Handshake edges:
  - len=0 -> done pulse in the cycle after start, busy never high.
  - start re-pulsed mid-playback -> ignored, timing unchanged.
  - s1..s4 changed mid-playback -> no effect on the LEDs.
- Reset mid-operation: assert reset during SHOW of pos=3.
  - Required: all outputs 0 immediately, without waiting for a clk edge; no done pulse.
  - Required: a new start after reset release plays from pos=0.
- OFF_CYCLES=0, ON_CYCLES=1, len=3.
  - Required: symbols on 3 consecutive cycles with no blank cycles; busy 3 cycles, done on the 4th.
